fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one sync FIFO write port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: per-requester data width, equal to the FIFO DATA_WIDTH.
REQ-003 The block SHALL have parameter ID_WIDTH, default 2: log2(NUM_REQ).
REQ-004 The block SHALL have parameter MAX_BURST, default 4: maximum beats per grant.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 3: beat counter width, able to hold MAX_BURST.
REQ-006 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-007 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 The block SHALL have port req_valid  input  NUM_REQ  per-requester data valid.
REQ-009 The block SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port req_ready  output  NUM_REQ  per-requester accept.
REQ-011 The block SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 The block SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-013 The block SHALL have port fifo_din  output  DATA_WIDTH  FIFO write data.
REQ-014 The block SHALL have port grant_valid  output  1  high while in GRANT.
REQ-015 The block SHALL have port grant_id  output  ID_WIDTH  index of the granted requester.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT.
REQ-017 In IDLE with any req_valid high, the block SHALL select round-robin starting at last_id+1 (mod NUM_REQ), register grant_id, and enter GRANT next cycle; arbitration latency is 1 cycle.
REQ-018 In IDLE with no req_valid high, the block SHALL remain in IDLE, with fifo_wr_en=0, req_ready=0 and fifo_din=0.
REQ-019 In GRANT, the block SHALL drive req_ready[grant_id] = !fifo_full and all other req_ready bits 0 (combinational).
REQ-020 In GRANT, the block SHALL drive fifo_wr_en = req_valid[grant_id] && !fifo_full and fifo_din = slice grant_id of req_data (combinational).
REQ-021 A beat SHALL be a cycle with fifo_wr_en=1; each beat increments beat_cnt by 1.
REQ-022 The grant SHALL be released (next state IDLE, last_id<=grant_id, beat_cnt<=0) when a beat brings beat_cnt to MAX_BURST, or when req_valid[grant_id] is 0 in GRANT.
REQ-023 While fifo_full=1 in GRANT with valid high, the block SHALL hold the grant, keep beat_cnt unchanged, and write nothing; the FIFO is never written while full.
REQ-024 req_valid changes on non-granted requesters SHALL have no effect until the next IDLE cycle.
REQ-025 grant_id and last_id SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-026 On rst=1 the block SHALL immediately force state=IDLE, grant_id=0, grant_valid=0, beat_cnt=0 and last_id=NUM_REQ-1, so requester 0 has first priority.
REQ-027 During reset and in the cycle after release, fifo_wr_en and req_ready SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no further writes; beats already written are not retracted.

Configuration
REQ-029 Macro ARB_BURST_EN SHALL select burst behaviour.
REQ-030 With ARB_BURST_EN defined, the grant SHALL be held for up to MAX_BURST beats per REQ-022.
REQ-031 Without ARB_BURST_EN, the grant SHALL be released after every single beat, as if MAX_BURST=1, and beat_cnt logic is omitted.

Verification
REQ-032 Scenario, single requester: reset, then req_valid=4'b0001 held with data 0x10,0x11,... and ARB_BURST_EN -> grant_id=0 one cycle later; 4 consecutive writes 0x10-0x13; 1 IDLE cycle; 4 more writes.
REQ-033 Scenario, all requesters: req_valid=4'b1111 continuously -> grant order 0,1,2,3,0; 4 beats each with ARB_BURST_EN, 1 beat each without it.
REQ-034 Scenario, full stall: fifo_full=1 for 3 cycles after beat 2 of a burst -> fifo_wr_en=0 and req_ready=0 for those cycles, grant_id unchanged, burst resumes at beat 3, total 4 beats.
REQ-035 Scenario, early drop: requester 2 deasserts valid after 2 beats -> release to IDLE; next grant goes to requester 3 if it is valid, with last_id=2.
REQ-036 Scenario, mid-burst reset: rst pulsed asynchronously between clock edges during beat 3 -> grant_valid=0 and fifo_wr_en=0 immediately; after release, the first grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters; 1-cycle arbitration, then combinational pass-through.
// fifo_full stalls the granted requester (ready low, no write); ARB_BURST_EN holds a grant for up to MAX_BURST beats, else 1 beat.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   last_id;
    logic [ID_WIDTH-1:0]   rr_id;
    logic [ID_WIDTH-1:0]   idx;
    logic                  rr_found;
    logic                  cur_valid;
    logic                  beat;
    logic                  burst_done;
    logic                  release_grant;
    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester after the last one served, wrapping at NUM_REQ.
    always_comb begin
        rr_id    = last_id;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(last_id) + k) % NUM_REQ);
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_id    = idx;
            end
        end
    end

    always_comb begin
        grant_valid = (state == ST_GRANT);
        cur_valid   = req_valid[grant_id];
        beat        = grant_valid && cur_valid && !fifo_full;
        fifo_wr_en  = beat;
        fifo_din    = grant_valid ? req_slice[grant_id] : '0;
        req_ready   = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

`ifdef ARB_BURST_EN
    logic [CNT_WIDTH-1:0] beat_cnt;

    assign burst_done = beat && (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (release_grant) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign burst_done = beat;
`endif

    assign release_grant = grant_valid && (!cur_valid || burst_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            last_id  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_id <= rr_id;
                        state    <= ST_GRANT;
                    end
                end
                default: begin
                    if (release_grant) begin
                        last_id <= grant_id;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a transaction-level reference model and scoreboard.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef ARB_BURST_EN
    localparam int BURST = 4;
`else
    localparam int BURST = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            grant_valid;
    logic [1:0]      grant_id;

    fifo_wr_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       gv;
        logic [1:0] gid;
        logic [3:0] rdy;
        logic       wr;
        logic [7:0] din;
    } st_t;

    wr_t        wr_q[$];
    st_t        st_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] nd [N];
    int         owner = -1;
    int         last  = N - 1;
    int         beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input logic [N-1:0] v, input logic full, input logic r);
        st_t s;
        wr_t w;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        fifo_full = full;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = nd[i];
        s = '{gv: 1'b0, gid: 2'd0, rdy: 4'd0, wr: 1'b0, din: 8'd0};
        if (r) begin
            owner = -1;
            last  = N - 1;
            beats = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && v[(last + k) % N]) owner = (last + k) % N;
            end
            beats = 0;
        end else begin
            s.gv  = 1'b1;
            s.gid = owner[1:0];
            s.din = nd[owner];
            if (!full) s.rdy[owner] = 1'b1;
            if (v[owner] && !full) begin
                s.wr = 1'b1;
                w.id = owner;
                w.d  = nd[owner];
                wr_q.push_back(w);
                nd[owner] = nd[owner] + 8'd1;
                beats++;
            end
            if (!v[owner] || beats == BURST) begin
                last  = owner;
                owner = -1;
                beats = 0;
            end
        end
        st_q.push_back(s);
    endtask

    // Monitor: every cycle against the status stream, every write against the write queue.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (st_q.size() == 0) begin
                chk("expectation_present", 32'd0, 32'd1);
            end else begin
                s = st_q.pop_front();
                chk("grant_valid", grant_valid, s.gv);
                chk("req_ready", req_ready, s.rdy);
                chk("fifo_wr_en", fifo_wr_en, s.wr);
                chk("fifo_din", fifo_din, s.din);
                if (s.gv) chk("grant_id", grant_id, s.gid);
            end
            if (fifo_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_data", fifo_din, w.d);
                    chk("write_id", grant_id, w.id);
                end
            end
        end
    end

    initial begin
        int  target;
        int  found;
        wr_t w;
        st_t z;
        for (int i = 0; i < N; i++) nd[i] = 8'h10 * (i + 1);

        repeat (3) step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);

        // Single requester with incrementing data from 0x10.
        repeat (12) step(4'b0001, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        // All requesters continuously valid.
        repeat (24) step(4'b1111, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        // FIFO full for three cycles after the second beat.
        for (int c = 0; c < 10; c++) step(4'b0010, (c >= 3 && c <= 5), 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        // Requester 2 drops valid after two beats; 3 and 0 waiting.
        repeat (3) step(4'b0100, 1'b0, 1'b0);
        repeat (8) step(4'b1001, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);

        // Reset between clock edges during the third beat of a burst.
        target = (BURST > 2) ? 2 : 0;
        found  = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step(4'b1111, 1'b0, 1'b0);
            if (owner >= 0 && beats == target) found = 1;
        end
        chk("reset_setup_reached", found, 1);
        step(4'b1111, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_req_ready", req_ready, 0);
        void'(st_q.pop_back());
        z = '{gv: 1'b0, gid: 2'd0, rdy: 4'd0, wr: 1'b0, din: 8'd0};
        st_q.push_back(z);
        if (found != 0 && wr_q.size() > 0) begin
            w = wr_q.pop_back();
            nd[w.id] = nd[w.id] - 8'd1;
        end
        owner = -1;
        last  = N - 1;
        beats = 0;
        repeat (2) step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        chk("first_grant_after_reset_valid", grant_valid, 1);
        chk("first_grant_after_reset_id", grant_id, 0);
        repeat (6) step(4'b1111, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (3) step(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("writes_drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
